// File: rtl/uart_word_tx_if.sv
// Word/byte-count handshake into the UART word transmitter.
// Master drives valid/data/count; slave answers with ready.
interface uart_word_tx_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;

  modport master (
    output in_valid,
    output in_data,
    output in_bytes,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_bytes,
    output in_ready
  );
endinterface

// File: rtl/uart_word_tx.sv
// Buffered UART word transmitter: 1-4 bytes per word, 8N1 frames, idle gap.
// Define UART_TX_PARITY_EN to add a parity bit (sense set by PARITY_ODD).
module uart_word_tx #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int GAP_BITS   = 10,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           nrst,
  uart_word_tx_if.slave  in_if,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_W =
    (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic PODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0] gap_idx_q, gap_idx_d;
  logic [31:0]      shreg_q, shreg_d;
  logic [2:0]       nbytes_q, nbytes_d;
  logic             tx_q, tx_d;

  logic [2:0]       bytes_clamped;
  logic             bit_end;
  logic             next_byte;

  // Counts 4..7 all mean a full word.
  always_comb begin
    unique case (1'b1)
      in_if.in_bytes[2]: bytes_clamped = 3'd4;
      default:           bytes_clamped = in_if.in_bytes;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      gap_idx_q <= '0;
      shreg_q   <= '0;
      nbytes_q  <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      gap_idx_q <= gap_idx_d;
      shreg_q   <= shreg_d;
      nbytes_q  <= nbytes_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    gap_idx_d = gap_idx_q;
    shreg_d   = shreg_q;
    nbytes_d  = nbytes_q;
    next_byte = 1'b0;
    bit_end   = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_if.in_valid && bytes_clamped != 3'd0) begin
          state_d   = S_START;
          shreg_d   = in_if.in_data;
          nbytes_d  = bytes_clamped;
          cnt_d     = '0;
          bit_idx_d = '0;
          gap_idx_d = '0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (GAP_BITS == 0) next_byte = 1'b1;
          else state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap_idx_q == GAP_LAST) begin
            gap_idx_d = '0;
            next_byte = 1'b1;
          end else begin
            gap_idx_d = gap_idx_q + GAP_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Next byte starts on the very next cycle, no idle slot.
    if (next_byte) begin
      shreg_d  = {8'h00, shreg_q[31:8]};
      nbytes_d = nbytes_q - 3'd1;
      state_d  = (nbytes_q == 3'd1) ? S_DONE : S_START;
    end
  end

  // tx is registered: its next value follows the next state.
  always_comb begin
    in_if.in_ready = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[bit_idx_d];
      S_PARITY: tx_d = (^shreg_d[7:0]) ^ PODD;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule
